vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Pixel-clock-domain video timing master and scan-out stage.
- Generates the raster counters consumed by pixel sources (sprite, bitmap layers) on their count_h/count_v inputs.
- Takes back the 8-bit RGB332 color those sources return a fixed number of cycles later, realigns sync/blanking to it, and drives the VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- COLOR_DELAY, 7, cycles from count issue to valid color_in

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- count_h  out  32 signed  horizontal raster position
- count_v  out  32 signed  vertical raster position
- color_in  in  8  RGB332 pixel from source, valid COLOR_DELAY cycles after its count
- frame_start  out  1  one-cycle pulse at count (0,0)
- vblank  out  1  high while count_v >= V_VISIBLE (undelayed)
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  display enable
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue

Behaviour:
- Reset: applied while reset==0 on a clk edge.
  - count_h=0, count_v=0, frame_start=0, vblank=0, vga_de=0, vga_r/g/b=0.
  - vga_hs=1, vga_vs=1 (inactive).
  - Delay-line contents cleared to the inactive/blank state.
- Totals: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- count_h increments every cycle. At H_TOTAL-1 it wraps to 0 and count_v increments. count_v wraps to 0 after V_TOTAL-1 together with count_h wrap. Counts are never negative; upper bits are 0.
- Raw (undelayed) timing, computed from the current counts:
  - de_raw = count_h<H_VISIBLE && count_v<V_VISIBLE.
  - hs_raw = 0 for count_h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752).
  - vs_raw = 0 for count_v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492).
- frame_start = 1 exactly in the cycle count_h==0 && count_v==0. It is not asserted during reset or in the first cycle after reset release.
- Alignment:
  - de_raw/hs_raw/vs_raw pass through a COLOR_DELAY-deep shift register.
  - The output register then samples the delayed values together with color_in.
  - Pixel issued at cycle t appears on vga_* at t+COLOR_DELAY+1 (8 by default). Sync and de for that pixel appear in the same cycle.
- Color expansion (registered):
  - vga_r = {c[7:5], c[7]}
  - vga_g = {c[4:2], c[4]}
  - vga_b = {c[1:0], c[1:0]}
  - All three are 0 when delayed de is 0, regardless of color_in.
- COLOR_DELAY=0 is legal: no delay stage, latency 1.
- Reset mid-frame: counters restart at (0,0) on the next edge after release. Blank and inactive syncs are output until the cleared delay line has flushed.

Decomposition:
- Shared package holds the VGA timing constants (the 8 defaults above, H_TOTAL, V_TOTAL, sync start/end) and the RGB332 field positions.
- Sub-module: the existing shift_register_vector with WIDTH=3, DEPTH=COLOR_DELAY carries {de, hs, vs}.
- That sub-module has no reset, so the wrapper masks its output, forcing blank and inactive syncs for COLOR_DELAY cycles after reset release.

Test Plan:
- Release reset, run 800*525 cycles.
  - frame_start pulses exactly once, at cycle 0 after release.
  - count_h reaches 799 then 0.
  - count_v reaches 524 then 0, with a pulse again at cycle 420000.
- Drive color_in=8'hE0 constantly.
  - vga_r=4'hF, g=0, b=0 only on cycles with vga_de=1.
  - Exactly 640*480 de cycles per frame.
- Model a 7-cycle delayed source returning color_in = count_h[7:0].
  - At the first visible output cycle (t=8), vga_r/g/b decode 8'h00.
  - At t=8+5 they decode 8'h05.
  - Confirms zero misalignment.
- Check hsync timing.
  - vga_hs low for exactly 96 cycles per line.
  - Falling edge 656+8 cycles after count_h==0 of that line.
- Check vsync timing.
  - vga_vs low for exactly 2*800 cycles.
  - Starts at line 490 (plus 8-cycle offset).
  - vblank high for lines 480..524.
- Assert reset=0 for 3 cycles at count (300,200).
  - All outputs hold reset values during reset.
  - After release: count restarts at (0,0), vga_de=0 and syncs high for 8 cycles.
  - Then normal output resumes.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// Shared VGA timing defaults, raster counter width and RGB332 field layout
// used by the scan-out stage and its delay line.
package vga_scanout_pkg;

   localparam int DEF_H_VISIBLE   = 640;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BACK      = 48;
   localparam int DEF_V_VISIBLE   = 480;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BACK      = 33;
   localparam int DEF_COLOR_DELAY = 7;

   localparam int DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   // Internal raster counter width; the 32-bit count ports are zero-extended.
   localparam int COUNT_W = 16;

   // MSB position of each RGB332 field.
   localparam int R_MSB = 7;
   localparam int G_MSB = 4;
   localparam int B_MSB = 1;

   typedef enum logic [1:0] {
      PH_HOLD,
      PH_FLUSH,
      PH_LIVE
   } phase_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   function automatic rgb444_t expand_rgb332(input logic [7:0] c);
      rgb444_t x;
      x.r = {c[R_MSB -: 3], c[R_MSB]};
      x.g = {c[G_MSB -: 3], c[G_MSB]};
      x.b = {c[B_MSB -: 2], c[B_MSB -: 2]};
      return x;
   endfunction

endpackage

// File: rtl/vga_scanout_shift_register_vector.sv
// Plain DEPTH-stage delay line for a WIDTH-bit vector, no reset.
// DEPTH of 0 degenerates to a wire.
module shift_register_vector #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0][WIDTH-1:0] taps;

         always_ff @(posedge clk) begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
               taps[i] <= taps[i-1];
            end
         end

         assign q = taps[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA timing master and scan-out: raster counters out, delayed RGB332 back in,
// sync/blank realigned to the returned color and registered onto the pins.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int H_VISIBLE   = DEF_H_VISIBLE,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int V_VISIBLE   = DEF_V_VISIBLE,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter int COLOR_DELAY = DEF_COLOR_DELAY
) (
   input  logic               clk,
   input  logic               reset,
   output logic signed [31:0] count_h,
   output logic signed [31:0] count_v,
   input  logic [7:0]         color_in,
   output logic               frame_start,
   output logic               vblank,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_de,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
   localparam logic [COUNT_W-1:0] H_VIS_C    = COUNT_W'(H_VISIBLE);
   localparam logic [COUNT_W-1:0] V_VIS_C    = COUNT_W'(V_VISIBLE);
   localparam logic [COUNT_W-1:0] HS_START_C = COUNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [COUNT_W-1:0] HS_END_C   = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [COUNT_W-1:0] VS_START_C = COUNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [COUNT_W-1:0] VS_END_C   = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam int FLUSH_W = (COLOR_DELAY > 1) ? $clog2(COLOR_DELAY) : 1;
   localparam logic [FLUSH_W-1:0] FLUSH_LAST =
      (COLOR_DELAY > 0) ? FLUSH_W'(COLOR_DELAY - 1) : '0;

   phase_t               phase_reg, phase_next;
   logic [FLUSH_W-1:0]   flush_reg, flush_next;
   logic [COUNT_W-1:0]   h_cnt_reg, h_cnt_next;
   logic [COUNT_W-1:0]   v_cnt_reg, v_cnt_next;
   logic                 counting;
   logic                 de_raw, hs_raw, vs_raw;
   logic [2:0]           timing_dly;
   logic                 dly_valid;
   logic                 de_dly, hs_dly, vs_dly;
   rgb444_t              pix;

   // HOLD covers the first edge after release so the raster starts at (0,0);
   // FLUSH then waits out the uninitialised delay line before trusting it.
   always_comb begin
      phase_next = phase_reg;
      flush_next = flush_reg;
      case (phase_reg)
         PH_HOLD: begin
            flush_next = '0;
            phase_next = (COLOR_DELAY == 0) ? PH_LIVE : PH_FLUSH;
         end
         PH_FLUSH: begin
            flush_next = flush_reg + 1'b1;
            if (flush_reg == FLUSH_LAST) begin
               phase_next = PH_LIVE;
            end
         end
         PH_LIVE: begin
            phase_next = PH_LIVE;
         end
         default: begin
            phase_next = PH_HOLD;
         end
      endcase
   end

   assign counting = (phase_reg != PH_HOLD);

   always_comb begin
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      if (counting) begin
         if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
         end else begin
            h_cnt_next = h_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_reg <= PH_HOLD;
         flush_reg <= '0;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         phase_reg <= phase_next;
         flush_reg <= flush_next;
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   assign count_h     = $signed(32'(h_cnt_reg));
   assign count_v     = $signed(32'(v_cnt_reg));
   assign frame_start = counting && (h_cnt_reg == '0) && (v_cnt_reg == '0);
   assign vblank      = (v_cnt_reg >= V_VIS_C);

   assign de_raw = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);
   assign hs_raw = !((h_cnt_reg >= HS_START_C) && (h_cnt_reg < HS_END_C));
   assign vs_raw = !((v_cnt_reg >= VS_START_C) && (v_cnt_reg < VS_END_C));

   shift_register_vector #(
      .WIDTH (3),
      .DEPTH (COLOR_DELAY)
   ) u_align (
      .clk (clk),
      .d   ({de_raw, hs_raw, vs_raw}),
      .q   (timing_dly)
   );

   assign dly_valid = (phase_reg == PH_LIVE);
   assign de_dly    = dly_valid & timing_dly[2];
   assign hs_dly    = ~dly_valid | timing_dly[1];
   assign vs_dly    = ~dly_valid | timing_dly[0];
   assign pix       = expand_rgb332(color_in);

   always_ff @(posedge clk) begin
      if (!reset) begin
         vga_de <= 1'b0;
         vga_hs <= 1'b1;
         vga_vs <= 1'b1;
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
      end else begin
         vga_de <= de_dly;
         vga_hs <= hs_dly;
         vga_vs <= vs_dly;
         vga_r  <= de_dly ? pix.r : 4'h0;
         vga_g  <= de_dly ? pix.g : 4'h0;
         vga_b  <= de_dly ? pix.b : 4'h0;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout; default horizontal timing, vertical raster
// shortened to 60 lines so a full frame plus a mid-frame reset stays short.
module tb_vga_scanout;

   localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = 800;
   localparam int VV = 48, VF = 4, VS = 2, VB = 6, VT = 60;
   localparam int FRAME = HT * VT;
   localparam int CD = 7;
   localparam int LAT = CD + 1;
   localparam int T_RST = FRAME + 20 * HT + 300;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [7:0]         color_in = 8'h00;
   logic signed [31:0] count_h, count_v;
   logic               frame_start, vblank, vga_hs, vga_vs, vga_de;
   logic [3:0]         vga_r, vga_g, vga_b;

   int checks = 0;
   int failures = 0;
   int t = 0;
   int mode = 0;
   bit first_run = 1'b1;
   logic [7:0] prev_color = 8'h00;
   logic prev_hs = 1'b1, prev_vs = 1'b1;

   int cnt_err = 0, fs_err = 0, vb_err = 0, de_err = 0, hs_err = 0, vs_err = 0, rgb_err = 0;
   int fs_total = 0, vb_total = 0, de_total = 0, max_h = 0, max_v = 0;
   int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;

   always #5 clk = ~clk;

   vga_scanout #(
      .H_VISIBLE   (HV),
      .H_FRONT     (HF),
      .H_SYNC      (HS),
      .H_BACK      (HB),
      .V_VISIBLE   (VV),
      .V_FRONT     (VF),
      .V_SYNC      (VS),
      .V_BACK      (VB),
      .COLOR_DELAY (CD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .count_h     (count_h),
      .count_v     (count_v),
      .color_in    (color_in),
      .frame_start (frame_start),
      .vblank      (vblank),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {de, hs, vs} for the pixel issued p cycles after the raster (re)started.
   function automatic logic [2:0] exp_sync(input int p);
      int h, v;
      if (p < 0) return 3'b011;
      h = p % HT;
      v = (p / HT) % VT;
      return {(h < HV) && (v < VV),
              !((h >= HV + HF) && (h < HV + HF + HS)),
              !((v >= VV + VF) && (v < VV + VF + VS))};
   endfunction

   function automatic logic [11:0] expand(input logic [7:0] c);
      return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
   endfunction

   task automatic cycle();
      logic [2:0]  es;
      logic [11:0] ec;
      logic [11:0] rgb;
      int eh, ev;
      @(posedge clk);
      #1;
      if (mode == 0) color_in = (t >= CD) ? 8'((t - CD) % HT) : 8'h00;
      else color_in = 8'hE0;
      @(negedge clk);
      eh  = t % HT;
      ev  = (t / HT) % VT;
      es  = exp_sync(t - LAT);
      ec  = es[2] ? expand(prev_color) : 12'h000;
      rgb = {vga_r, vga_g, vga_b};
      if (count_h !== eh || count_v !== ev) cnt_err++;
      if (frame_start !== (eh == 0 && ev == 0)) fs_err++;
      if (vblank !== (ev >= VV)) vb_err++;
      if (vga_de !== es[2]) de_err++;
      if (vga_hs !== es[1]) hs_err++;
      if (vga_vs !== es[0]) vs_err++;
      if (rgb !== ec) rgb_err++;
      if (first_run) begin
         if (t < FRAME) begin
            if (frame_start === 1'b1) fs_total++;
            if (vblank === 1'b1) vb_total++;
            if (count_h > max_h) max_h = count_h;
            if (count_v > max_v) max_v = count_v;
         end
         if (t >= LAT && t < FRAME + LAT && vga_de === 1'b1) de_total++;
         if (prev_hs === 1'b1 && vga_hs === 1'b0 && hs_fall < 0) hs_fall = t;
         if (prev_hs === 1'b0 && vga_hs === 1'b1 && hs_fall >= 0 && hs_rise < 0) hs_rise = t;
         if (prev_vs === 1'b1 && vga_vs === 1'b0 && vs_fall < 0) vs_fall = t;
         if (prev_vs === 1'b0 && vga_vs === 1'b1 && vs_fall >= 0 && vs_rise < 0) vs_rise = t;
         if (t == 0) begin
            check("start_h", count_h, 0);
            check("start_v", count_v, 0);
            check("start_frame_start", frame_start, 1);
         end
         if (t == LAT - 1) check("de_before_pix0", vga_de, 0);
         if (t == LAT) begin
            check("de_pix0", vga_de, 1);
            check("rgb_pix0", rgb, 12'h000);
         end
         if (t == LAT + 5) check("rgb_pix5", rgb, 12'h025);
         if (t == FRAME) check("frame_start_frame2", frame_start, 1);
         if (t == FRAME + LAT + 10) check("rgb_e0_visible", rgb, 12'hF00);
         if (t == FRAME + LAT + 700) check("rgb_e0_hblank", rgb, 12'h000);
      end else begin
         if (t == 0) begin
            check("restart_h", count_h, 0);
            check("restart_v", count_v, 0);
            check("restart_frame_start", frame_start, 1);
         end
         if (t == LAT - 1) begin
            check("flush_de", vga_de, 0);
            check("flush_hs", vga_hs, 1);
            check("flush_vs", vga_vs, 1);
         end
         if (t == LAT) begin
            check("resume_de", vga_de, 1);
            check("resume_rgb", rgb, 12'hF00);
         end
      end
      prev_hs    = vga_hs;
      prev_vs    = vga_vs;
      prev_color = color_in;
      t++;
   endtask

   initial begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_h", count_h, 0);
      check("rst_v", count_v, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_vblank", vblank, 0);
      check("rst_de", vga_de, 0);
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 1);
      check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      reset = 1'b1;

      // Counter-pattern source for one frame, then constant 8'hE0.
      mode = 0;
      while (t < FRAME) cycle();
      mode = 1;
      while (t <= T_RST) cycle();

      check("pre_reset_h", count_h, 300);
      check("pre_reset_v", count_v, 20);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("midrst_h", count_h, 0);
         check("midrst_v", count_v, 0);
         check("midrst_frame_start", frame_start, 0);
         check("midrst_vblank", vblank, 0);
         check("midrst_de", vga_de, 0);
         check("midrst_hs", vga_hs, 1);
         check("midrst_vs", vga_vs, 1);
         check("midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      end
      reset      = 1'b1;
      first_run  = 1'b0;
      t          = 0;
      prev_color = color_in;
      repeat (40) cycle();

      check("count_mismatches", cnt_err, 0);
      check("frame_start_mismatches", fs_err, 0);
      check("vblank_mismatches", vb_err, 0);
      check("de_mismatches", de_err, 0);
      check("hs_mismatches", hs_err, 0);
      check("vs_mismatches", vs_err, 0);
      check("rgb_mismatches", rgb_err, 0);
      check("frame_start_per_frame", fs_total, 1);
      check("max_count_h", max_h, HT - 1);
      check("max_count_v", max_v, VT - 1);
      check("de_cycles_per_frame", de_total, HV * VV);
      check("vblank_cycles_per_frame", vb_total, (VT - VV) * HT);
      check("hs_fall_cycle", hs_fall, HV + HF + LAT);
      check("hs_low_width", hs_rise - hs_fall, HS);
      check("vs_fall_cycle", vs_fall, (VV + VF) * HT + LAT);
      check("vs_low_width", vs_rise - vs_fall, VS * HT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
